// File: rtl/ila_capture_ctrl.sv
// ILA capture/trigger controller: writes probe samples into a circular sample memory and stops P samples after a masked trigger.
// Define ILA_EDGE_TRIG_EN to fire only on a rising edge of the match condition instead of on its level.
module ila_capture_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] probe_i,
  input  logic [DATA_WIDTH-1:0] trig_mask_i,
  input  logic [DATA_WIDTH-1:0] trig_value_i,
  input  logic [ADDR_WIDTH-1:0] post_count_i,
  output logic                  write_en_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] data_write_mem_o,
  output logic [ADDR_WIDTH-1:0] trig_addr_o,
  output logic [ADDR_WIDTH-1:0] start_addr_o,
  output logic                  done_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  match;
  logic                  trig_hit;
  logic                  arm_ok;
  logic                  capturing;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [ADDR_WIDTH-1:0] pre_cnt;
  logic [ADDR_WIDTH-1:0] arm_pre;

  assign match     = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  // post_count_i can never exceed DEPTH-1, so P needs no clamp and PRE = DEPTH-1-P is simply ~P.
  assign pre_cnt   = ~post_q;
  assign arm_pre   = ~post_count_i;
  assign cnt_inc   = cnt_q + 1'b1;
  assign arm_ok    = arm_i && ((state_q == IDLE) || (state_q == DONE));
  assign capturing = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);

`ifdef ILA_EDGE_TRIG_EN
  logic prev_match_q;

  // Tracking the match every cycle means the arm cycle seeds it, so a match already true at arm is not an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_match_q <= 1'b0;
    end else begin
      prev_match_q <= match;
    end
  end

  assign trig_hit = match && !prev_match_q;
`else
  assign trig_hit = match;
`endif

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    post_d       = post_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    write_en_d   = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    if (abort_i) begin
      state_d = IDLE;
    end else if (arm_ok) begin
      post_d  = post_count_i;
      wptr_d  = '0;
      cnt_d   = '0;
      state_d = (arm_pre == '0) ? ARMED : FILL;
    end else if (capturing) begin
      write_en_d = 1'b1;
      waddr_d    = wptr_q;
      wdata_d    = probe_i;
      wptr_d     = wptr_q + 1'b1;
      cnt_d      = cnt_inc;
      case (state_q)
        FILL: begin
          if (cnt_inc == pre_cnt) state_d = ARMED;
        end
        ARMED: begin
          if (trig_hit) begin
            trig_addr_d = wptr_q;
            cnt_d       = '0;
            if (post_q == '0) begin
              state_d      = DONE;
              start_addr_d = wptr_q + 1'b1;
            end else begin
              state_d = POST;
            end
          end
        end
        POST: begin
          // The buffer is full at this point, so the oldest sample sits at the next write address.
          if (cnt_inc == post_q) begin
            state_d      = DONE;
            start_addr_d = wptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      cnt_q        <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      write_en_q   <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      post_q       <= post_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      write_en_q   <= write_en_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign write_en_o       = write_en_q;
  assign waddr_o          = waddr_q;
  assign data_write_mem_o = wdata_q;
  assign trig_addr_o      = trig_addr_q;
  assign start_addr_o     = start_addr_q;
  assign done_o           = (state_q == DONE);
  assign state_o          = state_q;

endmodule
